port_queue_scheduler: RTL and testbench
=======================================

PORT_QUEUE_SCHEDULER -- requirements
Module: port_queue_scheduler

Interface
REQ-001 The block SHALL have parameter PORT_ID, default 2'd0: the output port (queue_sel[1:0]) this instance serves.
REQ-002 The block SHALL have parameter CNT_W, default 6: width of each per-priority packet counter.
REQ-003 The block SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port i_enq_valid, input, 1: one packet enqueued this cycle (crossbar column dat_valid).
REQ-006 The block SHALL have port i_enq_queue_sel, input, 5: bits [4:2] are the priority (7 highest), bits [1:0] are the dest port.
REQ-007 The block SHALL have port i_deq_ack, input, 1: the buffer read engine accepts the current dequeue request.
REQ-008 The block SHALL have port o_deq_req, output, 1: dequeue request pending.
REQ-009 The block SHALL have port o_deq_prio, output, 3: the priority queue to dequeue; valid while o_deq_req=1.
REQ-010 The block SHALL have port o_q_nonempty, output, 8: bit p is set when count[p] != 0.
REQ-011 The block SHALL have port o_enq_drop, output, 1: one-cycle pulse when an enqueue hits a saturated counter.

Function
REQ-012 An enqueue SHALL be accepted only when i_enq_valid=1 and i_enq_queue_sel[1:0]==PORT_ID; all other enqueues are ignored.
REQ-013 An accepted enqueue to priority p SHALL increment count[p] at that edge.
REQ-014 The deq engine SHALL decrement count[p] at the edge where o_deq_req=1 and i_deq_ack=1, with p=o_deq_prio.
REQ-015 Enqueue and dequeue on the same p in the same cycle SHALL leave count[p] unchanged.
REQ-016 An enqueue to p with count[p]==2^CNT_W-1 and no simultaneous dequeue of p SHALL leave the count saturated and pulse o_enq_drop high for exactly the next cycle.
REQ-017 The FSM SHALL have two states, IDLE and REQ.
REQ-018 In IDLE with any count nonzero, the FSM SHALL select priority p per REQ-022/023, register o_deq_prio=p and o_deq_req=1, and go to REQ; with all counts zero it SHALL stay in IDLE.
REQ-019 In REQ, o_deq_req and o_deq_prio SHALL be held stable until i_deq_ack=1; on ack, o_deq_req SHALL be 0 after that edge and the FSM SHALL return to IDLE (one bubble cycle between grants).
REQ-020 i_deq_ack while o_deq_req=0 SHALL be ignored.
REQ-021 Latency: for an enqueue sampled at edge t into an empty block, the count SHALL update at t and o_deq_req SHALL rise after edge t+1.
REQ-022 Default policy (weighted round robin): state ptr[2:0] and credit[3:0]; priority p is allowed p+1 consecutive grants.
REQ-023 Selection: if count[ptr]!=0 and credit<ptr+1, select ptr. Otherwise select the first nonempty queue scanning ptr-1, ptr-2, ... with wrap 0->7, then set ptr to it and clear credit. Credit SHALL increment on each ack.
REQ-024 o_q_nonempty SHALL reflect the registered counters combinationally.

Reset
REQ-025 On i_rst_n=0, asynchronously: all counts=0, state=IDLE, o_deq_req=0, o_deq_prio=0, o_enq_drop=0, ptr=7, credit=0.
REQ-026 Reset asserted mid-REQ SHALL abandon the request; no count is decremented.

Configuration
REQ-027 When the macro STRICT_PRIO_EN is defined, selection SHALL be strict priority: highest-numbered nonempty queue, and ptr/credit are unused. When it is undefined, REQ-022/023 apply.

Verification
REQ-028 Reset, then 3 enqueues of queue_sel=5'b111_00 (PORT_ID=0) on consecutive cycles -> o_q_nonempty=8'h80, o_deq_req rises 2 edges after the first enqueue with o_deq_prio=7.
REQ-029 Enqueue with queue_sel=5'b011_01 with PORT_ID=0 -> no count change, o_deq_req stays 0.
REQ-030 WRR with 10 packets in prio 7 and 10 in prio 1, ack always 1 -> grant sequence 7×8, then 1×2, then 7×2, then 1×8.
REQ-031 With STRICT_PRIO_EN defined, 2 packets in prio 0 and 1 in prio 5 -> grants 5, 0, 0.
REQ-032 CNT_W=2, 4 enqueues to prio 3 -> count=3, o_enq_drop pulses once; simultaneous enqueue+ack on prio 3 -> count stays 3 and no drop.
REQ-033 Assert i_rst_n=0 while o_deq_req=1 and i_deq_ack=0 -> o_deq_req=0 immediately, all counts 0, ptr=7.

Source files
------------

// File: rtl/port_queue_scheduler.sv
// Per-output-port priority queue scheduler: eight saturating packet counters
// and a two-state dequeue FSM. Define STRICT_PRIO_EN for strict priority instead of WRR.
module port_queue_scheduler #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         CNT_W   = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enq_valid,
  input  logic [4:0] i_enq_queue_sel,
  input  logic       i_deq_ack,
  output logic       o_deq_req,
  output logic [2:0] o_deq_prio,
  output logic [7:0] o_q_nonempty,
  output logic       o_enq_drop
);

  typedef enum logic {IDLE, REQ} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [2:0]       prio_q, prio_d;
  logic             drop_q, drop_d;
  logic             enq_acc, deq_fire;
  logic [7:0]       inc_v, dec_v;
  logic [2:0]       sel_prio;

  assign enq_acc  = i_enq_valid && (i_enq_queue_sel[1:0] == PORT_ID);
  assign deq_fire = (state_q == REQ) && i_deq_ack;
  assign inc_v    = enq_acc  ? (8'b1 << i_enq_queue_sel[4:2]) : 8'b0;
  assign dec_v    = deq_fire ? (8'b1 << prio_q) : 8'b0;

  always_comb begin
    drop_d       = 1'b0;
    o_q_nonempty = '0;
    for (int p = 0; p < 8; p++) begin
      cnt_d[p]        = cnt_q[p];
      o_q_nonempty[p] = |cnt_q[p];
      if (inc_v[p] && !dec_v[p]) begin
        if (cnt_q[p] == CNT_MAX) drop_d = 1'b1;
        else                     cnt_d[p] = cnt_q[p] + CNT_ONE;
      end else if (dec_v[p] && !inc_v[p] && (cnt_q[p] != '0)) begin
        cnt_d[p] = cnt_q[p] - CNT_ONE;
      end
    end
  end

`ifdef STRICT_PRIO_EN
  always_comb begin
    sel_prio = 3'd0;
    for (int p = 0; p < 8; p++) begin
      if (o_q_nonempty[p]) sel_prio = 3'(p);
    end
  end
`else
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] credit_q, credit_d;
  logic [2:0] scan_prio, scan_idx;
  logic       keep_ptr;

  // Walk offsets 8 down to 1 so the last hit is the nearest queue below ptr;
  // offset 8 lands on ptr itself, letting an exhausted ptr win when it is the only one left.
  always_comb begin
    scan_prio = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 8; k >= 1; k--) begin
      scan_idx = ptr_q - 3'(k);
      if (o_q_nonempty[scan_idx]) scan_prio = scan_idx;
    end
  end

  assign keep_ptr = o_q_nonempty[ptr_q] && (credit_q < ({1'b0, ptr_q} + 4'd1));
  assign sel_prio = keep_ptr ? ptr_q : scan_prio;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
`ifndef STRICT_PRIO_EN
    ptr_d    = ptr_q;
    credit_d = credit_q;
`endif
    case (state_q)
      IDLE: begin
        if (|o_q_nonempty) begin
          prio_d  = sel_prio;
          state_d = REQ;
`ifndef STRICT_PRIO_EN
          if (!keep_ptr) begin
            ptr_d    = scan_prio;
            credit_d = 4'd0;
          end
`endif
        end
      end
      REQ: begin
        if (i_deq_ack) begin
          state_d = IDLE;
`ifndef STRICT_PRIO_EN
          if (credit_q != 4'hF) credit_d = credit_q + 4'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      prio_q  <= 3'd0;
      drop_q  <= 1'b0;
      for (int p = 0; p < 8; p++) cnt_q[p] <= '0;
`ifndef STRICT_PRIO_EN
      ptr_q    <= 3'd7;
      credit_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      drop_q  <= drop_d;
      for (int p = 0; p < 8; p++) cnt_q[p] <= cnt_d[p];
`ifndef STRICT_PRIO_EN
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
`endif
    end
  end

  assign o_deq_req  = (state_q == REQ);
  assign o_deq_prio = prio_q;
  assign o_enq_drop = drop_q;

endmodule

// File: tb/tb_port_queue_scheduler.sv
// Directed bench for port_queue_scheduler: per-cycle vector table plus
// grant-order, saturation and mid-request reset sequences.
module tb_port_queue_scheduler;

  logic       clk;
  logic       rst_n;
  logic       a_en, a_ack, a_req, a_drop;
  logic [4:0] a_sel;
  logic [2:0] a_prio;
  logic [7:0] a_ne;
  logic       b_en, b_ack, b_req, b_drop;
  logic [4:0] b_sel;
  logic [2:0] b_prio;
  logic [7:0] b_ne;

  int checks   = 0;
  int failures = 0;

  port_queue_scheduler #(.PORT_ID(2'd0), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enq_valid(a_en), .i_enq_queue_sel(a_sel),
    .i_deq_ack(a_ack), .o_deq_req(a_req), .o_deq_prio(a_prio),
    .o_q_nonempty(a_ne), .o_enq_drop(a_drop));

  port_queue_scheduler #(.PORT_ID(2'd1), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enq_valid(b_en), .i_enq_queue_sel(b_sel),
    .i_deq_ack(b_ack), .o_deq_req(b_req), .o_deq_prio(b_prio),
    .o_q_nonempty(b_ne), .o_enq_drop(b_drop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [4:0] sel;
    logic       ack;
    logic       req;
    logic [2:0] prio;
    logic [7:0] ne;
    logic       drop;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    a_en = 0; a_sel = '0; a_ack = 0;
    b_en = 0; b_sel = '0; b_ack = 0;
    rst_n = 0;
    #2;
    step();
    rst_n = 1;
  endtask

  int         ngr;
  logic [2:0] gr     [20];
  logic [2:0] exp_gr [20];

  initial begin
    a_en = 0; a_sel = '0; a_ack = 0;
    b_en = 0; b_sel = '0; b_ack = 0;
    rst_n = 0;
    #12;
    chk("rst_req",  32'(a_req),  0);
    chk("rst_prio", 32'(a_prio), 0);
    chk("rst_ne",   32'(a_ne),   0);
    chk("rst_drop", 32'(a_drop), 0);
    chk("rst_b_req", 32'(b_req), 0);
`ifndef STRICT_PRIO_EN
    chk("rst_ptr",    32'(dut.ptr_q),    7);
    chk("rst_credit", 32'(dut.credit_q), 0);
`endif
    step();
    rst_n = 1;

    // en, sel, ack  |  expected req, prio, nonempty, drop after the edge
    tbl[0]  = '{1, 5'b111_00, 0,  0, 0, 8'h80, 0};
    tbl[1]  = '{1, 5'b111_00, 0,  1, 7, 8'h80, 0};
    tbl[2]  = '{1, 5'b111_00, 0,  1, 7, 8'h80, 0};
    tbl[3]  = '{1, 5'b011_01, 0,  1, 7, 8'h80, 0};
    tbl[4]  = '{1, 5'b010_00, 1,  0, 0, 8'h84, 0};
    tbl[5]  = '{0, 5'b111_00, 1,  1, 7, 8'h84, 0};
    tbl[6]  = '{1, 5'b111_00, 1,  0, 0, 8'h84, 0};
    tbl[7]  = '{0, 5'b000_00, 0,  1, 7, 8'h84, 0};
    tbl[8]  = '{0, 5'b000_00, 1,  0, 0, 8'h84, 0};
    tbl[9]  = '{0, 5'b000_00, 0,  1, 7, 8'h84, 0};
    tbl[10] = '{0, 5'b000_00, 1,  0, 0, 8'h04, 0};
    tbl[11] = '{0, 5'b000_00, 0,  1, 2, 8'h04, 0};
    tbl[12] = '{0, 5'b000_00, 1,  0, 0, 8'h00, 0};
    tbl[13] = '{0, 5'b000_00, 0,  0, 0, 8'h00, 0};

    for (int i = 0; i < 14; i++) begin
      a_en = tbl[i].en; a_sel = tbl[i].sel; a_ack = tbl[i].ack;
      step();
      chk($sformatf("vec%0d_req", i),  32'(a_req),  32'(tbl[i].req));
      chk($sformatf("vec%0d_ne", i),   32'(a_ne),   32'(tbl[i].ne));
      chk($sformatf("vec%0d_drop", i), 32'(a_drop), 32'(tbl[i].drop));
      if (tbl[i].req) chk($sformatf("vec%0d_prio", i), 32'(a_prio), 32'(tbl[i].prio));
    end

    // Grant order: 10 packets in prio 7 and 10 in prio 1, then ack held high
    reset_all();
    for (int i = 0; i < 20; i++) begin
      a_en = 1; a_sel = (i < 10) ? 5'b111_00 : 5'b001_00;
      step();
    end
    a_en = 0;
`ifdef STRICT_PRIO_EN
    for (int i = 0; i < 20; i++) exp_gr[i] = (i < 10) ? 3'd7 : 3'd1;
`else
    for (int i = 0; i < 20; i++)
      exp_gr[i] = (i < 8) ? 3'd7 : (i < 10) ? 3'd1 : (i < 12) ? 3'd7 : 3'd1;
`endif
    a_ack = 1;
    ngr = 0;
    for (int cyc = 0; cyc < 200 && ngr < 20; cyc++) begin
      if (a_req) begin gr[ngr] = a_prio; ngr++; end
      step();
    end
    a_ack = 0;
    chk("wrr_grant_count", 32'(ngr), 20);
    for (int i = 0; i < ngr; i++) chk($sformatf("wrr_grant%0d", i), 32'(gr[i]), 32'(exp_gr[i]));
    chk("wrr_empty", 32'(a_ne), 0);

    // One packet in prio 5 then two in prio 0
    reset_all();
    a_en = 1; a_sel = 5'b101_00; step();
    a_sel = 5'b000_00; step();
    step();
    a_en = 0;
    exp_gr[0] = 3'd5; exp_gr[1] = 3'd0; exp_gr[2] = 3'd0;
    a_ack = 1;
    ngr = 0;
    for (int cyc = 0; cyc < 40 && ngr < 3; cyc++) begin
      if (a_req) begin gr[ngr] = a_prio; ngr++; end
      step();
    end
    a_ack = 0;
    chk("p50_grant_count", 32'(ngr), 3);
    for (int i = 0; i < ngr; i++) chk($sformatf("p50_grant%0d", i), 32'(gr[i]), 32'(exp_gr[i]));
    chk("p50_empty", 32'(a_ne), 0);

    // Saturation on the 2-bit-counter instance (port 1, prio 3)
    reset_all();
    b_en = 1; b_sel = 5'b011_01;
    step(); chk("sat_drop1", 32'(b_drop), 0);
    step(); chk("sat_drop2", 32'(b_drop), 0);
    chk("sat_req", 32'(b_req), 1);
    chk("sat_prio", 32'(b_prio), 3);
    step(); chk("sat_drop3", 32'(b_drop), 0);
    step(); chk("sat_drop4", 32'(b_drop), 1);
    b_en = 0;
    step(); chk("sat_drop_off", 32'(b_drop), 0);
    b_en = 1; b_ack = 1;
    step();
    chk("sat_enqack_drop", 32'(b_drop), 0);
    chk("sat_enqack_req", 32'(b_req), 0);
    b_sel = 5'b011_00; b_ack = 0;
    step();
    b_en = 0;
    chk("sat_other_port_ne", 32'(b_ne), 32'h08);
    b_ack = 1;
    ngr = 0;
    for (int cyc = 0; cyc < 20 && b_ne != 0; cyc++) begin
      if (b_req) ngr++;
      step();
    end
    b_ack = 0;
    chk("sat_drain_count", 32'(ngr), 3);
    chk("sat_drain_empty", 32'(b_ne), 0);

    // Reset while a request is pending and unacknowledged
    reset_all();
    a_en = 1; a_sel = 5'b111_00; step();
    a_sel = 5'b001_00; step();
    a_en = 0;
    step();
    chk("midrst_pre_req", 32'(a_req), 1);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_req", 32'(a_req), 0);
    chk("midrst_ne",  32'(a_ne),  0);
`ifndef STRICT_PRIO_EN
    chk("midrst_ptr", 32'(dut.ptr_q), 7);
`endif
    step();
    rst_n = 1;
    step(); step();
    chk("midrst_after_req", 32'(a_req), 0);
    chk("midrst_after_ne",  32'(a_ne),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
